regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor register file for the RISC-V core: synchronous 2-read/1-write array with write-through bypass.
- Adds optional hardwired zero register, a per-register scoreboard (busy bits) for pipeline hazard detection, and a post-reset clear sequencer.
- Sits between decode (reads, issue) and writeback (write, complete).

Parameters:
- DATAWIDTH, 32, data bits per register.
- REGCOUNT, 32, number of registers; power of two, 2..256.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and issues; 0 = register 0 is ordinary.
- Localparam ADDRW = $clog2(REGCOUNT).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high once the clear sweep is done.
- readReg1  in  ADDRW  read port 1 index.
- readReg2  in  ADDRW  read port 2 index.
- readData1  out  DATAWIDTH  registered read data, port 1.
- readData2  out  DATAWIDTH  registered read data, port 2.
- busy1  out  1  registered busy status of readReg1.
- busy2  out  1  registered busy status of readReg2.
- write  in  1  write enable (writeback).
- writeReg  in  ADDRW  write index.
- writeData  in  DATAWIDTH  write data.
- issue  in  1  mark issueReg busy (pending producer).
- issueReg  in  ADDRW  index being reserved.
- flush  in  1  clear all busy bits.
- parity_err  out  1  parity error flag; present only with REGFILE_PARITY_EN.

Behaviour:
Reset:
- rst_n low (async): state=INIT, clear index=0, ready=0, readData1/2=0, busy1/2=0, all busy bits=0, parity_err=0.
- Reset asserted mid-sweep or in RUN aborts and restarts INIT.

FSM:
- INIT: each cycle, registers[idx]<=0 and idx increments.
- When idx==REGCOUNT-1, go to RUN. ready rises on the edge after the last clear, i.e. REGCOUNT cycles after rst_n deasserts.
- RUN: terminal until the next reset.

While INIT:
- write and issue are ignored.
- readData1/2 and busy1/2 register as 0.
- flush is ignored.

While RUN:
- Write: if write, registers[writeReg]<=writeData at the edge. Ignored if ZERO_REG and writeReg==0.
- Read latency 1: readDataN <= (write && writeReg==readRegN && !(ZERO_REG && readRegN==0)) ? writeData : registers[readRegN].
- ZERO_REG and readRegN==0 gives readDataN=0 always.
- Scoreboard update priority, per register r:
  - flush clears all bits.
  - Otherwise issue && issueReg==r sets bit r.
  - Otherwise write && writeReg==r clears bit r.
- issue and write to the same reg in the same cycle leave the bit set (new producer wins).
- flush overrides a same-cycle issue.
- issue/write to reg 0 never touch bit 0 when ZERO_REG.
- busyN is registered with bypass. busyN <= next-state value of bit readRegN: a same-cycle issue shows 1, a same-cycle completing write shows 0, flush shows 0. busy for reg 0 is always 0 when ZERO_REG.
- Both read ports may address the same register; both return identical data and busy.
- All indices are in range by construction (power-of-two REGCOUNT); there is no out-of-range case.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - Each register stores an extra even-parity bit (XOR of data) on write; INIT writes parity 0.
  - On each RUN read, the stored parity is checked for the selected non-bypassed, non-zero-reg entries.
  - parity_err is registered, aligned with readData, and high for one cycle per bad read. It is the OR of both ports.
  - Bypassed reads never flag.
  - The parity_err port exists.
- Undefined: no parity storage or check logic, and no parity_err port.

Test Plan:
- Reset sweep: REGCOUNT=32, release rst_n at cycle 0 -> ready=0 through cycle 31, ready=1 at edge 32; write asserted at cycle 10 has no effect (later read returns 0).
- Basic/bypass: write r5=0xDEADBEEF while readReg1=5 same cycle -> readData1=0xDEADBEEF next cycle; next cycle read r5 -> 0xDEADBEEF.
- Zero reg: ZERO_REG=1, write r0=0x1234, issue r0 -> readData=0, busy=0. ZERO_REG=0 repeat -> readData=0x1234 after write completes.
- Scoreboard: issue r7 -> busy1=1 on next read of r7; write r7=0x55 -> busy clears, same-cycle read shows busy1=0 and data 0x55; issue+write r7 same cycle -> busy stays 1.
- Flush/reset mid-op: issue r3,r4, assert flush with issue r9 -> all busy 0; pull rst_n low mid-RUN -> outputs 0 immediately, full 32-cycle sweep repeats.
- Parity (REGFILE_PARITY_EN): force-flip a stored bit of r2 via hierarchical deposit, read r2 -> parity_err=1 for one cycle; bypassed read of r2 -> parity_err=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with 2 registered read ports, write-through bypass, busy scoreboard and post-reset clear sweep.
// Optional even-parity storage and read check when REGFILE_PARITY_EN is defined.
module regfile_sb #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned REGCOUNT  = 32,
  parameter int unsigned ZERO_REG  = 1,
  localparam int unsigned ADDRW    = $clog2(REGCOUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic [ADDRW-1:0]     readReg1,
  input  logic [ADDRW-1:0]     readReg2,
  output logic [DATAWIDTH-1:0] readData1,
  output logic [DATAWIDTH-1:0] readData2,
  output logic                 busy1,
  output logic                 busy2,
  input  logic                 write,
  input  logic [ADDRW-1:0]     writeReg,
  input  logic [DATAWIDTH-1:0] writeData,
  input  logic                 issue,
  input  logic [ADDRW-1:0]     issueReg,
  input  logic                 flush
`ifdef REGFILE_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam logic [0:0]       ST_INIT  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(REGCOUNT - 1);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [ADDRW-1:0]     r_idx;
  logic [DATAWIDTH-1:0] r_regs [REGCOUNT];
  logic [REGCOUNT-1:0]  r_busy;
  logic [REGCOUNT-1:0]  w_busy_nxt;

  logic w_run;
  logic w_we;
  logic w_iss;
  logic w_zero1;
  logic w_zero2;
  logic w_byp1;
  logic w_byp2;

  assign w_run   = (r_state == ST_RUN);
  assign w_zero1 = (ZERO_REG != 0) && (readReg1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (readReg2 == '0);
  assign w_we    = w_run && write && !((ZERO_REG != 0) && (writeReg == '0));
  assign w_iss   = w_run && issue && !((ZERO_REG != 0) && (issueReg == '0));
  assign w_byp1  = w_we && (writeReg == readReg1);
  assign w_byp2  = w_we && (writeReg == readReg2);

  // Clear sweep runs once after reset, then RUN is terminal
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_idx == LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      ready   <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) r_idx <= r_idx + 1'b1;
    end
  end

  // Issue is applied after the write clear so a same-cycle new producer wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      if (flush) begin
        w_busy_nxt = '0;
      end else begin
        if (w_we)  w_busy_nxt[writeReg] = 1'b0;
        if (w_iss) w_busy_nxt[issueReg] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_regs[r_idx]   <= '0;
    else if (w_we)          r_regs[writeReg] <= writeData;
  end

`ifdef REGFILE_PARITY_EN
  logic r_par [REGCOUNT];
  logic w_perr1;
  logic w_perr2;

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) r_par[r_idx]   <= 1'b0;
    else if (w_we)          r_par[writeReg] <= ^writeData;
  end

  assign w_perr1 = !w_zero1 && !w_byp1 && ((^r_regs[readReg1]) != r_par[readReg1]);
  assign w_perr2 = !w_zero2 && !w_byp2 && ((^r_regs[readReg2]) != r_par[readReg2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= w_run && (w_perr1 || w_perr2);
  end
`endif

  // Read ports: bypass the in-flight write, busy shows the post-edge scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData1 <= '0;
      readData2 <= '0;
      busy1     <= 1'b0;
      busy2     <= 1'b0;
    end else begin
      readData1 <= (!w_run || w_zero1) ? '0 : (w_byp1 ? writeData : r_regs[readReg1]);
      readData2 <= (!w_run || w_zero2) ? '0 : (w_byp2 ? writeData : r_regs[readReg2]);
      busy1     <= w_run && !w_zero1 && w_busy_nxt[readReg1];
      busy2     <= w_run && !w_zero2 && w_busy_nxt[readReg2];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (ZERO_REG=1 and ZERO_REG=0) on shared inputs, checked against an array model.
`timescale 1ns/1ps
module tb_regfile_sb;

  localparam int unsigned RC = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        write = 1'b0, issue = 1'b0, flush = 1'b0;
  logic [4:0]  writeReg = '0, issueReg = '0, readReg1 = '0, readReg2 = '0;
  logic [31:0] writeData = '0;

  logic        rdy_z, b1_z, b2_z, rdy_o, b1_o, b2_o;
  logic [31:0] d1_z, d2_z, d1_o, d2_o;
`ifdef REGFILE_PARITY_EN
  logic        pe_z, pe_o;
  logic        exp_pe_z = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg  [2][RC];
  logic        m_busy [2][RC];
  int          m_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.DATAWIDTH(32), .REGCOUNT(RC), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .ready(rdy_z),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(d1_z), .readData2(d2_z),
    .busy1(b1_z), .busy2(b2_z), .write(write), .writeReg(writeReg), .writeData(writeData),
    .issue(issue), .issueReg(issueReg), .flush(flush)
`ifdef REGFILE_PARITY_EN
    , .parity_err(pe_z)
`endif
  );

  regfile_sb #(.DATAWIDTH(32), .REGCOUNT(RC), .ZERO_REG(0)) dut_o (
    .clk(clk), .rst_n(rst_n), .ready(rdy_o),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(d1_o), .readData2(d2_o),
    .busy1(b1_o), .busy2(b2_o), .write(write), .writeReg(writeReg), .writeData(writeData),
    .issue(issue), .issueReg(issueReg), .flush(flush)
`ifdef REGFILE_PARITY_EN
    , .parity_err(pe_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic isz(input int z, input logic [4:0] r);
    return (z == 1) && (r == 5'd0);
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++)
      for (int r = 0; r < RC; r++) begin
        m_reg[z][r]  = '0;
        m_busy[z][r] = 1'b0;
      end
    m_cnt = 0;
  endtask

  // One clock: drive inputs, predict from the model, compare after the edge, advance the model
  task automatic cyc(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                     input logic is, input logic [4:0] ir, input logic fl,
                     input logic [4:0] r1, input logic [4:0] r2);
    logic        run, e_rdy;
    logic [31:0] e_d1 [2];
    logic [31:0] e_d2 [2];
    logic        e_b1 [2];
    logic        e_b2 [2];
    logic        nb   [2][RC];
    write = w; writeReg = wr; writeData = wd;
    issue = is; issueReg = ir; flush = fl;
    readReg1 = r1; readReg2 = r2;
    run   = (m_cnt >= RC);
    e_rdy = ((m_cnt + 1) >= RC);
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < RC; r++) begin
        nb[z][r] = m_busy[z][r];
        if (run) begin
          if (fl)                                        nb[z][r] = 1'b0;
          else if (is && ir == 5'(r) && !isz(z, 5'(r)))  nb[z][r] = 1'b1;
          else if (w && wr == 5'(r) && !isz(z, 5'(r)))   nb[z][r] = 1'b0;
        end
      end
      e_d1[z] = (!run || isz(z, r1)) ? 32'h0 : ((w && wr == r1) ? wd : m_reg[z][r1]);
      e_d2[z] = (!run || isz(z, r2)) ? 32'h0 : ((w && wr == r2) ? wd : m_reg[z][r2]);
      e_b1[z] = run && nb[z][r1];
      e_b2[z] = run && nb[z][r2];
    end
    @(posedge clk);
    #1;
    chk("ready_z", 32'(rdy_z), 32'(e_rdy));
    chk("ready_o", 32'(rdy_o), 32'(e_rdy));
    chk($sformatf("rd1_z r%0d", r1), d1_z, e_d1[1]);
    chk($sformatf("rd2_z r%0d", r2), d2_z, e_d2[1]);
    chk($sformatf("rd1_o r%0d", r1), d1_o, e_d1[0]);
    chk($sformatf("rd2_o r%0d", r2), d2_o, e_d2[0]);
    chk($sformatf("busy1_z r%0d", r1), 32'(b1_z), 32'(e_b1[1]));
    chk($sformatf("busy2_z r%0d", r2), 32'(b2_z), 32'(e_b2[1]));
    chk($sformatf("busy1_o r%0d", r1), 32'(b1_o), 32'(e_b1[0]));
    chk($sformatf("busy2_o r%0d", r2), 32'(b2_o), 32'(e_b2[0]));
`ifdef REGFILE_PARITY_EN
    chk("perr_z", 32'(pe_z), 32'(exp_pe_z));
    chk("perr_o", 32'(pe_o), 32'h0);
`endif
    for (int z = 0; z < 2; z++) begin
      if (run) begin
        if (w && !isz(z, wr)) m_reg[z][wr] = wd;
        for (int r = 0; r < RC; r++) m_busy[z][r] = nb[z][r];
      end
    end
    if (m_cnt < RC) m_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst ready_z", 32'(rdy_z), 32'h0);
    chk("rst ready_o", 32'(rdy_o), 32'h0);
    chk("rst rd1_z", d1_z, 32'h0);
    chk("rst rd2_o", d2_o, 32'h0);
    chk("rst busy1_z", 32'(b1_z), 32'h0);
    chk("rst busy2_o", 32'(b2_o), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [4:0] rnd_a();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic rnd_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 1) == 1, rnd_a(), $urandom, $urandom_range(0, 9) < 4, rnd_a(),
          $urandom_range(0, 99) < 3, rnd_a(), rnd_a());
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        is;
    logic [4:0]  ir;
    logic        fl;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Expected values are for the ZERO_REG=1 instance, starting from a freshly cleared file
    tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd10, 5'd10, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd7,  32'h0,        32'h0,        1'b1, 1'b1};
    tbl[7]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 1'b0, 5'd7,  5'd7,  32'h55,       32'h55,       1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd7, 32'h66,       1'b1, 5'd7, 1'b0, 5'd7,  5'd7,  32'h66,       32'h66,       1'b1, 1'b1};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7,  5'd7,  32'h66,       32'h66,       1'b1, 1'b1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3,  5'd3,  32'h0,        32'h0,        1'b1, 1'b1};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd4,  5'd3,  32'h0,        32'h0,        1'b1, 1'b1};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd9,  5'd3,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd4,  5'd9,  32'h0,        32'h0,        1'b0, 1'b0};

    model_reset();
    #2;
    do_reset();

    // Sweep: writes/issues during INIT must be ignored (write to r10 at cycle 10)
    for (int i = 0; i < int'(RC); i++)
      cyc(i == 10, 5'd10, 32'hAAAA5555, i == 12, 5'd11, 1'b0, 5'd10, 5'(i));

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].w, tbl[i].wr, tbl[i].wd, tbl[i].is, tbl[i].ir, tbl[i].fl, tbl[i].r1, tbl[i].r2);
      chk($sformatf("tbl%0d rd1", i), d1_z, tbl[i].e1);
      chk($sformatf("tbl%0d rd2", i), d2_z, tbl[i].e2);
      chk($sformatf("tbl%0d busy1", i), 32'(b1_z), 32'(tbl[i].eb1));
      chk($sformatf("tbl%0d busy2", i), 32'(b2_z), 32'(tbl[i].eb2));
    end

`ifdef REGFILE_PARITY_EN
    cyc(1'b1, 5'd2, 32'h000000F1, 1'b0, 5'd0, 1'b0, 5'd1, 5'd1);
    dut_z.r_regs[2] = dut_z.r_regs[2] ^ 32'h1;
    m_reg[1][2] = m_reg[1][2] ^ 32'h1;
    exp_pe_z = 1'b1;
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd1);
    exp_pe_z = 1'b0;
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd1);
    cyc(1'b1, 5'd2, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd2, 5'd2);
`endif

    rnd_cycles(600);

    // Reset in RUN: outputs drop at once and the full sweep repeats
    do_reset();
    for (int i = 0; i < int'(RC); i++)
      cyc(1'b1, 5'(i), $urandom, 1'b1, 5'(i), 1'b0, 5'(i), rnd_a());
    rnd_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
